// File: rtl/wb_ram_bank_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ram_bank_arbiter
//
// Two-port Wishbone B3 classic slave sharing a set of synchronous 32-bit,
// byte-write-enabled RAM banks (one-cycle read latency) between two masters.
// Requests are arbitrated round-robin, the byte address is split into bank
// select and word address, the RAM access is sequenced, and read data is
// returned with ack (or err for addresses beyond the populated banks).
//
// One transaction takes three cycles: IDLE (grant) -> ACCESS (RAM enabled)
// -> RESP (ack + read data). Out-of-range requests go IDLE -> ERR -> IDLE.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   m{0,1}_cyc_i/_stb_i/_we_i  Wishbone controls per master
//   m{0,1}_adr_i               byte address
//   m{0,1}_sel_i               byte lanes
//   m{0,1}_dat_i / _dat_o      write / read data
//   m{0,1}_ack_o / _err_o      termination
//   ram_bank_sel               one-hot bank enable (ACCESS cycle only)
//   ram_we                     byte write enables, shared by all banks
//   ram_din                    write data
//   ram_waddr / ram_raddr      word address within bank, zero-extended
//   ram_dout                   bank read data, bank k at [32k+31:32k]
// ---------------------------------------------------------------------------

// Per-port address decoder: word index, bank index and out-of-range flag.
module wb_ram_bank_decode #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_AW   = 11,
    parameter int BSEL_W    = 2
) (
    input  logic [31:0]        adr_i,
    output logic [BANK_AW-1:0] word_o,
    output logic [BSEL_W-1:0]  bank_o,
    output logic               oor_o
);
    localparam int BANK_LSB = BANK_AW + 2;
    localparam int TOP_LSB  = BANK_LSB + $clog2(NUM_BANKS);

    logic [31:0] top_bits;
    logic        adr_unused;

    // Byte offset within the word is irrelevant: lanes come from sel.
    assign adr_unused = ^adr_i[1:0];

    always_comb begin
        word_o   = adr_i[BANK_AW+1:2];
        // Masking handles NUM_BANKS == 1, where the bank field is empty.
        bank_o   = BSEL_W'(adr_i >> BANK_LSB) & BSEL_W'(NUM_BANKS - 1);
        top_bits = adr_i >> TOP_LSB;
        oor_o    = |top_bits;
    end
endmodule

module wb_ram_bank_arbiter #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_AW   = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [31:0]             m0_adr_i,
    input  logic [3:0]              m0_sel_i,
    input  logic [31:0]             m0_dat_i,
    output logic [31:0]             m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [31:0]             m1_adr_i,
    input  logic [3:0]              m1_sel_i,
    input  logic [31:0]             m1_dat_i,
    output logic [31:0]             m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,

    output logic [NUM_BANKS-1:0]    ram_bank_sel,
    output logic [3:0]              ram_we,
    output logic [31:0]             ram_din,
    output logic [15:0]             ram_waddr,
    output logic [15:0]             ram_raddr,
    input  logic [32*NUM_BANKS-1:0] ram_dout
);
    localparam int NUM_PORTS = 2;
    localparam int BSEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    // Port-indexed views of the two Wishbone slaves.
    logic [NUM_PORTS-1:0]              cyc, stb, we, req;
    logic [NUM_PORTS-1:0][31:0]        adr, wdat, rdat;
    logic [NUM_PORTS-1:0][3:0]         sel;
    logic [NUM_PORTS-1:0][BANK_AW-1:0] dec_word;
    logic [NUM_PORTS-1:0][BSEL_W-1:0]  dec_bank;
    logic [NUM_PORTS-1:0]              dec_oor, ack, err;

    assign cyc  = {m1_cyc_i, m0_cyc_i};
    assign stb  = {m1_stb_i, m0_stb_i};
    assign we   = {m1_we_i,  m0_we_i};
    assign adr  = {m1_adr_i, m0_adr_i};
    assign sel  = {m1_sel_i, m0_sel_i};
    assign wdat = {m1_dat_i, m0_dat_i};
    assign req  = cyc & stb;

    assign m0_dat_o = rdat[0];
    assign m0_ack_o = ack[0];
    assign m0_err_o = err[0];
    assign m1_dat_o = rdat[1];
    assign m1_ack_o = ack[1];
    assign m1_err_o = err[1];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        wb_ram_bank_decode #(
            .NUM_BANKS (NUM_BANKS),
            .BANK_AW   (BANK_AW),
            .BSEL_W    (BSEL_W)
        ) u_dec (
            .adr_i  (adr[p]),
            .word_o (dec_word[p]),
            .bank_o (dec_bank[p]),
            .oor_o  (dec_oor[p])
        );
    end

    // -----------------------------------------------------------------------
    // Transaction state: everything the access needs is latched at grant so
    // the master may change adr/dat afterwards without effect.
    // -----------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        dat_q, dat_d;
    logic [BANK_AW-1:0] word_q, word_d;
    logic [BSEL_W-1:0]  bank_q, bank_d;
    logic               pick;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        word_d  = word_q;
        bank_d  = bank_q;
        // Contention goes to the port not served last; otherwise the lone
        // requester (req[1] is 1 only when port 1 is the one asking).
        pick    = (req == 2'b11) ? ~last_q : req[1];

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    last_d  = pick;
                    we_d    = we[pick];
                    sel_d   = sel[pick];
                    dat_d   = wdat[pick];
                    word_d  = dec_word[pick];
                    bank_d  = dec_bank[pick];
                    state_d = dec_oor[pick] ? S_ERR : S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            word_q  <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            word_q  <= word_d;
            bank_q  <= bank_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs are decoded straight from registered state, so an asynchronous
    // reset clears every one of them in the same cycle rst_n falls.
    // -----------------------------------------------------------------------
    logic        in_access;
    logic [31:0] bank_rdata;

    assign in_access    = (state_q == S_ACCESS);
    assign ram_bank_sel = in_access ? (NUM_BANKS'(1) << bank_q) : '0;
    assign ram_we       = (in_access && we_q) ? sel_q : 4'h0;
    assign ram_din      = in_access ? dat_q : 32'h0;
    assign ram_waddr    = in_access ? 16'(word_q) : 16'h0;
    assign ram_raddr    = in_access ? 16'(word_q) : 16'h0;

    // The bank captured its read word at the end of ACCESS and holds it
    // while disabled, so the slice is valid throughout RESP.
    assign bank_rdata   = ram_dout[bank_q*32 +: 32];

    // Termination follows the master's live cyc: a master that abandoned
    // the cycle sees nothing, but the RAM access itself still completed.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_resp
        logic mine;
        assign mine    = (grant_q == 1'(p)) && cyc[p];
        assign ack[p]  = (state_q == S_RESP) && mine;
        assign err[p]  = (state_q == S_ERR) && mine;
        assign rdat[p] = (ack[p] && !we_q) ? bank_rdata : 32'h0;
    end

    a_one_term_per_port: assert property (@(posedge clk) disable iff (!rst_n)
        !(ack[0] && err[0]) && !(ack[1] && err[1]));
    a_one_port_at_a_time: assert property (@(posedge clk) disable iff (!rst_n)
        !((ack[0] || err[0]) && (ack[1] || err[1])));
endmodule

// File: tb/tb_wb_ram_bank_arbiter.sv
module tb_wb_ram_bank_arbiter;
    localparam int NB = 4;
    localparam int AW = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [31:0] m0_adr_i = 0, m0_dat_i = 0;
    logic [3:0]  m0_sel_i = 0;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [31:0] m1_adr_i = 0, m1_dat_i = 0;
    logic [3:0]  m1_sel_i = 0;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic [NB-1:0]      ram_bank_sel;
    logic [3:0]         ram_we;
    logic [31:0]        ram_din;
    logic [15:0]        ram_waddr, ram_raddr;
    logic [32*NB-1:0]   ram_dout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_ram_bank_arbiter #(.NUM_BANKS(NB), .BANK_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .ram_bank_sel(ram_bank_sel), .ram_we(ram_we), .ram_din(ram_din),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    // Byte-write BRAM model, read-first, output held while disabled.
    logic [31:0] mem [NB][2**AW];
    logic [31:0] dout_q [NB];
    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (ram_bank_sel[k]) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[k][ram_waddr[AW-1:0]][8*b +: 8] <= ram_din[8*b +: 8];
                dout_q[k] <= mem[k][ram_raddr[AW-1:0]];
            end
        end
    end
    always_comb for (int k = 0; k < NB; k++) ram_dout[32*k +: 32] = dout_q[k];

    wire [177:0] all_out = {ram_bank_sel, ram_we, ram_din, ram_waddr, ram_raddr,
                            m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o};

    task automatic drive(input int p, input logic c, input logic w,
                         input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        if (p == 0) begin
            m0_cyc_i = c; m0_stb_i = c; m0_we_i = w; m0_adr_i = a; m0_sel_i = s; m0_dat_i = d;
        end else begin
            m1_cyc_i = c; m1_stb_i = c; m1_we_i = w; m1_adr_i = a; m1_sel_i = s; m1_dat_i = d;
        end
    endtask

    // One bounded transaction from an idle bus; captures the cycle after the
    // sampling edge (ACCESS or ERR) and the termination.
    logic [31:0] x_rd, x_din;
    int          x_lat;
    logic        x_ack, x_err;
    logic [3:0]  x_bsel, x_we;
    logic [15:0] x_waddr, x_raddr;

    task automatic xfer(input int p, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        @(posedge clk); #1;
        x_lat = 0; x_ack = 0; x_err = 0; x_rd = 0;
        drive(p, 1'b1, w, a, s, d);
        while (!x_ack && !x_err && x_lat < 8) begin
            @(posedge clk); #1;
            x_lat++;
            if (x_lat == 1) begin
                x_bsel = ram_bank_sel; x_we = ram_we; x_waddr = ram_waddr;
                x_raddr = ram_raddr; x_din = ram_din;
            end
            if (p == 0) begin x_ack = m0_ack_o; x_err = m0_err_o; x_rd = m0_dat_o; end
            else        begin x_ack = m1_ack_o; x_err = m1_err_o; x_rd = m1_dat_o; end
        end
        drive(p, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", all_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'h5555_AAAA);
        @(posedge clk); #1;
        checks++;
        if (ram_we !== 4'hF || ram_bank_sel !== 4'b0001) begin
            failures++; $display("FAIL reset_pre_access we=%h bsel=%b want F/0001", ram_we, ram_bank_sel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_mid_access got=%h want=0", all_out);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(0, 1'b1, 32'h0000_0010, 4'hF, 32'h0BAD_F00D);
        checks++;
        if (!x_ack || x_err || x_lat != 2 || x_bsel !== 4'b0001 || x_waddr !== 16'd4) begin
            failures++;
            $display("FAIL reset_first_grant ack=%b err=%b lat=%0d bsel=%b waddr=%h want 1/0/2/0001/4",
                     x_ack, x_err, x_lat, x_bsel, x_waddr);
        end
    endtask

    task automatic test_write_read;
        xfer(0, 1'b1, 32'h0000_2004, 4'hF, 32'hDEAD_BEEF);
        checks++;
        if (x_bsel !== 4'b0010 || x_waddr !== 16'd1 || x_raddr !== 16'd1 || x_we !== 4'hF ||
            x_din !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_access bsel=%b waddr=%h raddr=%h we=%h din=%h want 0010/1/1/F/DEADBEEF",
                     x_bsel, x_waddr, x_raddr, x_we, x_din);
        end
        checks++;
        if (!x_ack || x_lat != 2 || x_rd !== 32'h0) begin
            failures++; $display("FAIL write_ack ack=%b lat=%0d dat=%h want 1/2/0", x_ack, x_lat, x_rd);
        end
        xfer(0, 1'b0, 32'h0000_2004, 4'hF, 32'h0);
        checks++;
        if (!x_ack || x_lat != 2 || x_we !== 4'h0 || x_rd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL readback ack=%b lat=%0d we=%h dat=%h want 1/2/0/DEADBEEF", x_ack, x_lat, x_we, x_rd);
        end
    endtask

    task automatic test_byte_write;
        xfer(0, 1'b1, 32'h0000_2004, 4'b0100, 32'h00AA_0000);
        checks++;
        if (x_we !== 4'b0100 || !x_ack) begin
            failures++; $display("FAIL byte_we we=%b ack=%b want 0100/1", x_we, x_ack);
        end
        xfer(0, 1'b1, 32'h0000_2004, 4'b0000, 32'hFFFF_FFFF);
        checks++;
        if (x_we !== 4'h0 || !x_ack || x_lat != 2) begin
            failures++; $display("FAIL sel0_write we=%h ack=%b lat=%0d want 0/1/2", x_we, x_ack, x_lat);
        end
        xfer(0, 1'b0, 32'h0000_2004, 4'hF, 32'h0);
        checks++;
        if (x_rd !== 32'hDEAA_BEEF) begin
            failures++; $display("FAIL byte_readback got=%h want DEAABEEF", x_rd);
        end
        // Port 1, last word of bank 3.
        xfer(1, 1'b1, 32'h0000_7FFC, 4'hF, 32'hCAFE_F00D);
        checks++;
        if (!x_ack || x_bsel !== 4'b1000 || x_waddr !== 16'h07FF) begin
            failures++; $display("FAIL p1_top_word ack=%b bsel=%b waddr=%h want 1/1000/7FF", x_ack, x_bsel, x_waddr);
        end
    endtask

    task automatic test_latch;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h0000_2008, 4'hF, 32'h1234_5678);
        @(posedge clk); #1;
        m0_adr_i = 32'h0000_6000;
        m0_dat_i = 32'h0;
        #1;
        checks++;
        if (ram_bank_sel !== 4'b0010 || ram_waddr !== 16'd2 || ram_din !== 32'h1234_5678) begin
            failures++;
            $display("FAIL latched_addr bsel=%b waddr=%h din=%h want 0010/2/12345678", ram_bank_sel, ram_waddr, ram_din);
        end
        @(posedge clk); #1;
        checks++;
        if (m0_ack_o !== 1'b1) begin
            failures++; $display("FAIL latched_ack got=%b want 1", m0_ack_o);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        xfer(0, 1'b0, 32'h0000_2008, 4'hF, 32'h0);
        checks++;
        if (x_rd !== 32'h1234_5678) begin
            failures++; $display("FAIL latched_readback got=%h want 12345678", x_rd);
        end
    endtask

    task automatic test_out_of_range;
        xfer(1, 1'b0, 32'h0000_8000, 4'hF, 32'h0);
        checks++;
        if (!x_err || x_ack || x_lat != 1 || x_bsel !== 4'b0000 || x_we !== 4'h0) begin
            failures++;
            $display("FAIL oor_p1 err=%b ack=%b lat=%0d bsel=%b we=%h want 1/0/1/0000/0",
                     x_err, x_ack, x_lat, x_bsel, x_we);
        end
        xfer(0, 1'b1, 32'h8000_2004, 4'hF, 32'h0);
        checks++;
        if (!x_err || x_ack || x_lat != 1 || x_bsel !== 4'b0000) begin
            failures++; $display("FAIL oor_p0_high err=%b ack=%b lat=%0d bsel=%b want 1/0/1/0000", x_err, x_ack, x_lat, x_bsel);
        end
        xfer(0, 1'b0, 32'h0000_2004, 4'hF, 32'h0);
        checks++;
        if (x_rd !== 32'hDEAA_BEEF || x_lat != 2) begin
            failures++; $display("FAIL oor_no_write got=%h lat=%0d want DEAABEEF/2", x_rd, x_lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] a0, a1, e0, e1;
        logic [31:0] d0, d1;
        int          overlap;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0; overlap = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h0000_2004, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0000_7FFC, 4'hF, 32'h0);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            a0[i] = m0_ack_o;
            a1[i] = m1_ack_o;
            if (i == 2) d0 = m0_dat_o;
            if (i == 5) d1 = m1_dat_o;
            if ((m0_ack_o || m0_err_o) && (m1_ack_o || m1_err_o)) overlap++;
            if (m0_err_o || m1_err_o) overlap++;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        e0 = 13'b0_0001_0000_0100;   // cycles 2, 8
        e1 = 13'b0_1000_0010_0000;   // cycles 5, 11
        checks++;
        if (a0 !== e0) begin
            failures++; $display("FAIL rr_port0_acks got=%b want=%b", a0, e0);
        end
        checks++;
        if (a1 !== e1) begin
            failures++; $display("FAIL rr_port1_acks got=%b want=%b", a1, e1);
        end
        checks++;
        if (overlap != 0) begin
            failures++; $display("FAIL rr_overlap got=%0d want=0", overlap);
        end
        checks++;
        if (d0 !== 32'hDEAA_BEEF || d1 !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL rr_data got=%h/%h want DEAABEEF/CAFEF00D", d0, d1);
        end
    endtask

    task automatic test_drop_cyc;
        logic [6:0] a0, a1;
        logic [31:0] d1;
        logic        e0;
        a0 = '0; a1 = '0; d1 = '0; e0 = 1'b0;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h0000_2004, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0000_7FFC, 4'hF, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            a0[i] = m0_ack_o;
            a1[i] = m1_ack_o;
            e0 = e0 | m0_err_o;
            if (i == 5) d1 = m1_dat_o;
            if (i == 1) drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (a0 !== 7'b0 || e0 !== 1'b0) begin
            failures++; $display("FAIL drop_no_ack acks=%b err=%b want 0/0", a0, e0);
        end
        checks++;
        if (a1 !== 7'b010_0000 || d1 !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL drop_next_p1 acks=%b dat=%h want 0100000/CAFEF00D", a1, d1);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_latch();
        test_out_of_range();
        test_back_to_back();
        test_drop_cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_ram_bank_arbiter.md
# wb_ram_bank_arbiter

Two-port Wishbone B3 classic slave that shares a set of synchronous 32-bit RAM banks (byte-write-enabled BRAM banks, one-cycle read latency) between two masters, e.g. CPU instruction and data buses. Arbitrates round-robin, decodes the byte address into bank select and word address, sequences the RAM access, and returns read data with ack/err. Sits between the SoC interconnect and the RAM bank instances.

## Interface
- NUM_BANKS, 4, number of RAM banks (power of two, 1..8)
- BANK_AW, 11, word-address bits per bank (bank depth 2^BANK_AW words)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1  port 0 Wishbone controls
- m0_adr_i  in  32  port 0 byte address
- m0_sel_i  in  4  port 0 byte lanes
- m0_dat_i  in  32  port 0 write data
- m0_dat_o  out  32  port 0 read data
- m0_ack_o, m0_err_o  out  1  port 0 termination
- m1_*  same set as m0_* for port 1
- ram_bank_sel  out  NUM_BANKS  one-hot bank enable
- ram_we  out  4  byte write enables, shared by all banks
- ram_din  out  32  write data
- ram_waddr, ram_raddr  out  16  word address within bank, zero-extended
- ram_dout  in  32*NUM_BANKS  bank read data, bank k at [32k+31:32k]

## Operation
- Decode per port: word = adr[BANK_AW+1:2]; bank = next log2(NUM_BANKS) bits; any set bit above the bank field = out of range. adr[1:0] ignored.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE: request on port p = cyc&stb. If none, stay. If one, grant it. If both, grant the port not granted last (last_grant resets to 1, so port 0 wins first contention). On grant: latch port, we, sel, dat, word, bank; update last_grant. In range -> ACCESS; out of range -> ERR.
- ACCESS (1 cycle): ram_bank_sel one-hot for latched bank; ram_waddr = ram_raddr = word; ram_din = latched data; ram_we = latched sel if write, else 0. -> RESP.
- RESP (1 cycle): all ram_* strobes 0; granted port ack_o = 1; for reads dat_o = ram_dout slice of latched bank (BRAM holds output while disabled); writes dat_o = 0. -> IDLE.
- ERR (1 cycle): no RAM activity; granted port err_o = 1. -> IDLE.
- Non-granted port: ack_o/err_o/dat_o = 0; its request stays pending and is served at the next IDLE.
- Write with sel = 0: full sequence, ram_we = 0, ack returned, memory unchanged.
- Master drops cyc during ACCESS/RESP: sequence completes (write still performed), ack/err gated by the port's current cyc (not asserted if cyc low); return to IDLE.
- ack and err never both high; never asserted on both ports in the same cycle.

## Timing
- Reset (rst_n low, asynchronous, any state incl. mid-transaction): state IDLE, last_grant = 1, all outputs 0 (ram_bank_sel, ram_we, ram_din, ram_waddr, ram_raddr, m*_dat_o, m*_ack_o, m*_err_o). Interrupted write may or may not have landed in RAM; no ack issued.
- Request sampled high at edge N (in IDLE) -> ACCESS during cycle N+1 -> ack during cycle N+2 -> IDLE at N+3. Read latency 2 cycles from sampling edge to ack; one transaction per 3 cycles.
- Out-of-range: err during cycle N+1, IDLE at N+2.
- Back-to-back with both ports continuously requesting: grants alternate 0,1,0,1 every 3 cycles.
- Port changing adr/dat after grant has no effect; latched values used.

## Test plan
- Reset mid-ACCESS of a port-0 write -> all outputs 0 same cycle as rst_n falls; after release first port-0 request granted normally.
- Port 0 writes 0xDEADBEEF to byte addr 0x0000_2004 (bank 1, word 1), sel=4'hF -> ram_bank_sel=4'b0010, ram_waddr=1, ram_we=4'hF in ACCESS, ack 2 cycles after request; readback returns 0xDEADBEEF.
- Byte write sel=4'b0100 data 0x00AA0000 to same word -> ram_we=4'b0100; readback 0xDEAABEEF.
- Both ports request simultaneously from reset, holding requests -> grants 0,1,0,1; each ack 3 cycles apart, never overlapping.
- Port 1 access to 0x0000_8000 (above 4 banks × 8 KB) -> m1_err_o one cycle, ram_bank_sel stays 0, no ack.
- Port 0 drops cyc in ACCESS of a read -> no m0_ack_o; FSM back in IDLE; pending port-1 request served next.
